// File: rtl/dfr0520_pkg.sv
// rtl/dfr0520_pkg.sv - shared command codes, defaults and FSM state type for the DFR0520 responder
package dfr0520_pkg;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_SHDN  = 2'b10;
  localparam logic [1:0] CMD_NOP3  = 2'b11;

  localparam int         FRAME_BITS_DEFAULT  = 16;
  localparam logic [7:0] WIPER_RESET_DEFAULT = 8'h80;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    OVER   = 2'd2,
    COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/dfr0520_spi_responder_if.sv
// rtl/dfr0520_spi_responder_if.sv - SPI pins and pot-state outputs of the DFR0520 responder
interface dfr0520_spi_responder_if;

  logic       CS;
  logic       SCK;
  logic       MOSI;
  logic [7:0] wiper0;
  logic [7:0] wiper1;
  logic       shdn0;
  logic       shdn1;
  logic [1:0] last_cmd;
  logic [1:0] last_sel;
  logic       frame_valid;
  logic       frame_err;

  modport master (
    output CS, SCK, MOSI,
    input  wiper0, wiper1, shdn0, shdn1, last_cmd, last_sel, frame_valid, frame_err
  );

  modport slave (
    input  CS, SCK, MOSI,
    output wiper0, wiper1, shdn0, shdn1, last_cmd, last_sel, frame_valid, frame_err
  );

endinterface

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - synchronizers and edge detect for the asynchronous SPI pins
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic cs_in,
  input  logic sck_in,
  input  logic mosi_in,
  output logic cs_s,
  output logic sck_rise,
  output logic cs_rise,
  output logic cs_fall,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   cs_hist_q;
  logic                   sck_hist_q;

  // Reset values mirror an idle bus: deselected, clock low.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cs_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_hist_q   <= 1'b1;
      sck_hist_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_in};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_in};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
      cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
      sck_hist_q  <= sck_sync_q[SYNC_STAGES-1];
    end
  end

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_sync_q[SYNC_STAGES-1] & ~sck_hist_q;
  assign cs_rise  = cs_sync_q[SYNC_STAGES-1] & ~cs_hist_q;
  assign cs_fall  = ~cs_sync_q[SYNC_STAGES-1] & cs_hist_q;

endmodule

// File: rtl/dfr0520_spi_responder.sv
// rtl/dfr0520_spi_responder.sv - DFR0520 dual digipot SPI responder: frame capture, decode, wiper registers
module dfr0520_spi_responder
  import dfr0520_pkg::*;
#(
  parameter int         FRAME_BITS  = FRAME_BITS_DEFAULT,
  parameter logic [7:0] WIPER_RESET = WIPER_RESET_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input logic                     clk_in,
  input logic                     rst,
  dfr0520_spi_responder_if.slave  bus
);

  localparam int             CNT_W     = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

  logic cs_s, sck_rise, cs_rise, cs_fall, mosi_s;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in   (clk_in),
    .rst      (rst),
    .cs_in    (bus.CS),
    .sck_in   (bus.SCK),
    .mosi_in  (bus.MOSI),
    .cs_s     (cs_s),
    .sck_rise (sck_rise),
    .cs_rise  (cs_rise),
    .cs_fall  (cs_fall),
    .mosi_s   (mosi_s)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [1:0]       sel_q, sel_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       wiper0_q, wiper0_d, wiper1_q, wiper1_d;
  logic             shdn0_q, shdn0_d, shdn1_q, shdn1_d;
  logic [1:0]       last_cmd_q, last_cmd_d, last_sel_q, last_sel_d;
  logic             frame_valid_q, frame_valid_d, frame_err_q, frame_err_d;
  logic [SYNC_STAGES:0] settle_q;
  logic             armed_q, armed_d;

  // A CS already low when reset releases must not open a frame: only arm
  // cs_fall once the synchronizer holds real pin data and has seen CS high.
  assign armed_d = armed_q | (settle_q[SYNC_STAGES] & cs_s);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
      cmd_q         <= '0;
      sel_q         <= '0;
      data_q        <= '0;
      wiper0_q      <= WIPER_RESET;
      wiper1_q      <= WIPER_RESET;
      shdn0_q       <= 1'b0;
      shdn1_q       <= 1'b0;
      last_cmd_q    <= '0;
      last_sel_q    <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      settle_q      <= '0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ovf_q         <= ovf_d;
      cmd_q         <= cmd_d;
      sel_q         <= sel_d;
      data_q        <= data_d;
      wiper0_q      <= wiper0_d;
      wiper1_q      <= wiper1_d;
      shdn0_q       <= shdn0_d;
      shdn1_q       <= shdn1_d;
      last_cmd_q    <= last_cmd_d;
      last_sel_q    <= last_sel_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      settle_q      <= {settle_q[SYNC_STAGES-1:0], 1'b1};
      armed_q       <= armed_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ovf_d         = ovf_q;
    cmd_d         = cmd_q;
    sel_d         = sel_q;
    data_d        = data_q;
    wiper0_d      = wiper0_q;
    wiper1_d      = wiper1_q;
    shdn0_d       = shdn0_q;
    shdn1_d       = shdn1_q;
    last_cmd_d    = last_cmd_q;
    last_sel_d    = last_sel_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = RECV;
        end
      end

      RECV: begin
        if (cs_rise) begin
          state_d = COMMIT;
        end else if (sck_rise) begin
          if (cnt_q == FRAME_CNT) begin
            ovf_d   = 1'b1;
            state_d = OVER;
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            data_d = {data_q[6:0], mosi_s};
            // Only the cmd (frame bits 13:12) and sel (9:8) fields are kept;
            // the rest of the command byte is don't-care.
            if (cnt_q == CNT_W'(2) || cnt_q == CNT_W'(3)) begin
              cmd_d = {cmd_q[0], mosi_s};
            end
            if (cnt_q == CNT_W'(6) || cnt_q == CNT_W'(7)) begin
              sel_d = {sel_q[0], mosi_s};
            end
          end
        end
      end

      OVER: begin
        if (cs_rise) begin
          state_d = COMMIT;
        end
      end

      COMMIT: begin
        state_d = IDLE;
        if (!ovf_q && cnt_q == FRAME_CNT) begin
          frame_valid_d = 1'b1;
          last_cmd_d    = cmd_q;
          last_sel_d    = sel_q;
          case (cmd_q)
            CMD_WRITE: begin
              if (sel_q[0]) begin
                wiper0_d = data_q;
                shdn0_d  = 1'b0;
              end
              if (sel_q[1]) begin
                wiper1_d = data_q;
                shdn1_d  = 1'b0;
              end
            end
            CMD_SHDN: begin
              if (sel_q[0]) shdn0_d = 1'b1;
              if (sel_q[1]) shdn1_d = 1'b1;
            end
            CMD_NOP, CMD_NOP3: begin
            end
          endcase
        end else if (ovf_q || cnt_q != '0) begin
          frame_err_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.wiper0      = wiper0_q;
  assign bus.wiper1      = wiper1_q;
  assign bus.shdn0       = shdn0_q;
  assign bus.shdn1       = shdn1_q;
  assign bus.last_cmd    = last_cmd_q;
  assign bus.last_sel    = last_sel_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_dfr0520_spi_responder.sv
// tb/tb_dfr0520_spi_responder.sv - directed self-checking bench for the DFR0520 SPI responder
module tb_dfr0520_spi_responder;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  dfr0520_spi_responder_if bus();

  dfr0520_spi_responder dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;
  int vcnt     = 0;
  int ecnt     = 0;

  always @(negedge clk_in) begin
    if (bus.frame_valid === 1'b1) vcnt++;
    if (bus.frame_err === 1'b1)   ecnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic spi_bits(input logic [23:0] value, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      bus.MOSI = value[i];
      wait_clk(4);
      bus.SCK = 1'b1;
      wait_clk(4);
      bus.SCK = 1'b0;
    end
  endtask

  task automatic cs_low();
    bus.CS = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high();
    wait_clk(4);
    bus.CS = 1'b1;
    wait_clk(12);
  endtask

  task automatic send_frame(input logic [23:0] value, input int nbits);
    cs_low();
    if (nbits > 0) spi_bits(value, nbits - 1, 0);
    cs_high();
  endtask

  task automatic check_state(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                             input logic s0, input logic s1);
    check({tag, "_wiper0"}, 32'(bus.wiper0), 32'(w0));
    check({tag, "_wiper1"}, 32'(bus.wiper1), 32'(w1));
    check({tag, "_shdn0"},  32'(bus.shdn0),  32'(s0));
    check({tag, "_shdn1"},  32'(bus.shdn1),  32'(s1));
  endtask

  initial begin
    bus.CS   = 1'b1;
    bus.SCK  = 1'b0;
    bus.MOSI = 1'b0;
    wait_clk(3);
    check_state("reset", 8'h80, 8'h80, 1'b0, 1'b0);
    check("reset_last_cmd", 32'(bus.last_cmd), 32'd0);
    check("reset_last_sel", 32'(bus.last_sel), 32'd0);
    check("reset_valid", 32'(bus.frame_valid), 32'd0);
    check("reset_err", 32'(bus.frame_err), 32'd0);
    rst = 1'b0;
    wait_clk(10);

    send_frame(24'h0011AA, 16);
    check_state("wr_pot0", 8'hAA, 8'h80, 1'b0, 1'b0);
    check("wr_pot0_vcnt", 32'(vcnt), 32'd1);
    check("wr_pot0_ecnt", 32'(ecnt), 32'd0);
    check("wr_pot0_last_cmd", 32'(bus.last_cmd), 32'd1);
    check("wr_pot0_last_sel", 32'(bus.last_sel), 32'd1);

    send_frame(24'h0013F1, 16);
    check_state("wr_both", 8'hF1, 8'hF1, 1'b0, 1'b0);
    send_frame(24'h002300, 16);
    check_state("shdn_both", 8'hF1, 8'hF1, 1'b1, 1'b1);
    check("shdn_last_cmd", 32'(bus.last_cmd), 32'd2);
    check("shdn_vcnt", 32'(vcnt), 32'd3);

    send_frame(24'h001110, 16);
    check_state("wake_pot0", 8'h10, 8'hF1, 1'b0, 1'b1);
    check("wake_vcnt", 32'(vcnt), 32'd4);

    send_frame(24'h00011A, 12);
    check("short_ecnt", 32'(ecnt), 32'd1);
    check("short_vcnt", 32'(vcnt), 32'd4);
    send_frame(24'h012355, 17);
    check("long_ecnt", 32'(ecnt), 32'd2);
    check("long_vcnt", 32'(vcnt), 32'd4);
    check_state("after_err", 8'h10, 8'hF1, 1'b0, 1'b1);
    send_frame(24'h000000, 0);
    check("empty_ecnt", 32'(ecnt), 32'd2);
    check("empty_vcnt", 32'(vcnt), 32'd4);

    send_frame(24'h000155, 16);
    check("nop_vcnt", 32'(vcnt), 32'd5);
    check("nop_last_cmd", 32'(bus.last_cmd), 32'd0);
    check("nop_last_sel", 32'(bus.last_sel), 32'd1);
    send_frame(24'h001055, 16);
    check("sel0_vcnt", 32'(vcnt), 32'd6);
    check("sel0_last_cmd", 32'(bus.last_cmd), 32'd1);
    check("sel0_last_sel", 32'(bus.last_sel), 32'd0);
    check_state("nop_sel0", 8'h10, 8'hF1, 1'b0, 1'b1);

    cs_low();
    spi_bits(24'h001233, 15, 7);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    spi_bits(24'h001233, 6, 0);
    cs_high();
    check_state("rst_mid", 8'h80, 8'h80, 1'b0, 1'b0);
    check("rst_mid_last_cmd", 32'(bus.last_cmd), 32'd0);
    check("rst_mid_vcnt", 32'(vcnt), 32'd6);
    check("rst_mid_ecnt", 32'(ecnt), 32'd2);
    send_frame(24'h001233, 16);
    check_state("post_rst", 8'h80, 8'h33, 1'b0, 1'b0);
    check("post_rst_vcnt", 32'(vcnt), 32'd7);
    check("post_rst_last_sel", 32'(bus.last_sel), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
